// File: rtl/video_mnist_seg_param_pkg.sv
// video_mnist_seg_param_pkg: register map, control/status bits, ID and FSM states of the parameter scheduler
package video_mnist_seg_param_pkg;
  localparam logic [31:0] ADR_ID = 32'd0;
  localparam logic [31:0] ADR_CTL = 32'd1;
  localparam logic [31:0] ADR_STATUS = 32'd2;
  localparam logic [31:0] ADR_FRAME_CNT = 32'd3;
  localparam logic [31:0] ADR_MODE = 32'd4;
  localparam logic [31:0] ADR_TH = 32'd5;
  localparam logic [31:0] ADR_MODE_ACT = 32'd6;
  localparam logic [31:0] ADR_TH_ACT = 32'd7;
  localparam logic [31:0] ADR_CYCLE = 32'd8;
  localparam int CTL_REQ = 0;
  localparam int CTL_ALWAYS = 1;
  localparam int STATUS_PENDING = 0;
  localparam logic [31:0] ID_VALUE = 32'h5345_4743;
  typedef enum logic {IDLE, WAIT_FRAME} state_t;
  function automatic logic [2:0] mode_next(input logic [2:0] m, input int num);
    return (int'(m) >= num - 1) ? 3'd0 : m + 3'd1;
  endfunction
endpackage

// File: rtl/video_mnist_seg_param_sched_if.sv
// video_mnist_seg_param_sched_if: Wishbone slave bus of the parameter scheduler
interface video_mnist_seg_param_sched_if #(
  parameter int WB_ADR_WIDTH = 8,
  parameter int WB_DAT_WIDTH = 32,
  parameter int WB_SEL_WIDTH = WB_DAT_WIDTH / 8
);
  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i;
  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i;
  logic [WB_DAT_WIDTH-1:0] s_wb_dat_o;
  logic s_wb_we_i;
  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i;
  logic s_wb_stb_i;
  logic s_wb_ack_o;
  modport master (
    output s_wb_adr_i, s_wb_dat_i, s_wb_we_i, s_wb_sel_i, s_wb_stb_i,
    input s_wb_dat_o, s_wb_ack_o
  );
  modport slave (
    input s_wb_adr_i, s_wb_dat_i, s_wb_we_i, s_wb_sel_i, s_wb_stb_i,
    output s_wb_dat_o, s_wb_ack_o
  );
endinterface

// File: rtl/video_mnist_seg_param_regs.sv
// video_mnist_seg_param_regs: Wishbone decode, shadow mode/threshold and optional auto mode cycling
// (auto cycling built only with VIDEO_MNIST_SEG_PARAM_SCHED_AUTO_CYCLE_EN)
module video_mnist_seg_param_regs
  import video_mnist_seg_param_pkg::*;
#(
  parameter int TCOUNT_WIDTH = 4,
  parameter int WB_ADR_WIDTH = 8,
  parameter int WB_DAT_WIDTH = 32,
  parameter int WB_SEL_WIDTH = WB_DAT_WIDTH / 8,
  parameter logic [2:0] INIT_PARAM_MODE = 3'b010,
  parameter int INIT_PARAM_TH = 5,
  parameter int MODE_NUM = 5
) (
  input logic aclk,
  input logic aresetn,
  video_mnist_seg_param_sched_if.slave s_wb,
  input logic frame_start,
  input logic pending,
  input logic [31:0] frame_cnt,
  input logic [2:0] act_mode,
  input logic [TCOUNT_WIDTH-1:0] act_th,
  output logic [2:0] shadow_mode,
  output logic [TCOUNT_WIDTH-1:0] shadow_th,
  output logic always_en,
  output logic req,
  output logic shadow_chg
);
  logic [WB_ADR_WIDTH-1:0] adr_w;
  logic [WB_SEL_WIDTH-1:0] unused_sel;
  logic [31:0] adr, wd, rd, cyc_rd;
  logic wr, wr_ctl, wr_mode, wr_th, tick;
  logic unused;
  assign adr_w = s_wb.s_wb_adr_i;
  assign unused_sel = s_wb.s_wb_sel_i;
  assign adr = 32'(adr_w);
  assign wd = 32'(s_wb.s_wb_dat_i);
  assign unused = ^{wd, unused_sel};
  assign wr = s_wb.s_wb_stb_i & s_wb.s_wb_we_i;
  assign wr_ctl = wr && adr == ADR_CTL;
  assign wr_mode = wr && adr == ADR_MODE;
  assign wr_th = wr && adr == ADR_TH;
  assign s_wb.s_wb_ack_o = s_wb.s_wb_stb_i;
  assign s_wb.s_wb_dat_o = WB_DAT_WIDTH'(rd);
`ifdef VIDEO_MNIST_SEG_PARAM_SCHED_AUTO_CYCLE_EN
  logic [15:0] cycle_frames, cyc_cnt;
  logic wr_cyc;
  assign wr_cyc = wr && adr == ADR_CYCLE;
  assign tick = frame_start && cycle_frames != 16'd0 && cyc_cnt >= cycle_frames - 16'd1;
  assign cyc_rd = {16'd0, cycle_frames};
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      cycle_frames <= '0;
      cyc_cnt <= '0;
    end else begin
      cycle_frames <= wr_cyc ? wd[15:0] : cycle_frames;
      cyc_cnt <= (cycle_frames == 16'd0 || tick) ? 16'd0 : cyc_cnt + 16'(frame_start);
    end
`else
  assign tick = 1'b0;
  assign cyc_rd = '0;
`endif
  // a host mode write in the same cycle as an auto advance takes priority
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      shadow_mode <= INIT_PARAM_MODE;
      shadow_th <= TCOUNT_WIDTH'(INIT_PARAM_TH);
      always_en <= 1'b0;
    end else begin
      shadow_mode <= wr_mode ? wd[2:0] : tick ? mode_next(shadow_mode, MODE_NUM) : shadow_mode;
      shadow_th <= wr_th ? wd[TCOUNT_WIDTH-1:0] : shadow_th;
      always_en <= wr_ctl ? wd[CTL_ALWAYS] : always_en;
    end
  assign req = (wr_ctl & wd[CTL_REQ]) | tick;
  assign shadow_chg = wr_mode | wr_th | tick;
  always_comb begin
    rd = '0;
    case (adr)
      ADR_ID: rd = ID_VALUE;
      ADR_CTL: rd = 32'(always_en) << CTL_ALWAYS;
      ADR_STATUS: rd = 32'(pending) << STATUS_PENDING;
      ADR_FRAME_CNT: rd = frame_cnt;
      ADR_MODE: rd = 32'(shadow_mode);
      ADR_TH: rd = 32'(shadow_th);
      ADR_MODE_ACT: rd = 32'(act_mode);
      ADR_TH_ACT: rd = 32'(act_th);
      ADR_CYCLE: rd = cyc_rd;
      default: rd = '0;
    endcase
  end
endmodule

// File: rtl/video_mnist_seg_param_sched.sv
// video_mnist_seg_param_sched: commits Wishbone shadow mode/threshold to the colour core only at frame start
// (optional auto mode cycling: VIDEO_MNIST_SEG_PARAM_SCHED_AUTO_CYCLE_EN)
module video_mnist_seg_param_sched
  import video_mnist_seg_param_pkg::*;
#(
  parameter int TCOUNT_WIDTH = 4,
  parameter int WB_ADR_WIDTH = 8,
  parameter int WB_DAT_WIDTH = 32,
  parameter int WB_SEL_WIDTH = WB_DAT_WIDTH / 8,
  parameter logic [2:0] INIT_PARAM_MODE = 3'b010,
  parameter int INIT_PARAM_TH = 5,
  parameter int TIMEOUT_CYCLES = 2 ** 20,
  parameter int MODE_NUM = 5
) (
  input logic aresetn,
  input logic aclk,
  video_mnist_seg_param_sched_if.slave s_wb,
  input logic mon_tuser,
  input logic mon_tvalid,
  input logic mon_tready,
  output logic [2:0] param_mode,
  output logic [TCOUNT_WIDTH-1:0] param_th,
  output logic update_pending
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  state_t state, state_nx;
  logic [TW-1:0] timer;
  logic [31:0] frame_cnt;
  logic [2:0] shadow_mode;
  logic [TCOUNT_WIDTH-1:0] shadow_th;
  logic frame_start, timeout, commit, always_en, req, shadow_chg;
  video_mnist_seg_param_regs #(
    .TCOUNT_WIDTH(TCOUNT_WIDTH),
    .WB_ADR_WIDTH(WB_ADR_WIDTH),
    .WB_DAT_WIDTH(WB_DAT_WIDTH),
    .WB_SEL_WIDTH(WB_SEL_WIDTH),
    .INIT_PARAM_MODE(INIT_PARAM_MODE),
    .INIT_PARAM_TH(INIT_PARAM_TH),
    .MODE_NUM(MODE_NUM)
  ) u_regs (
    .aclk(aclk),
    .aresetn(aresetn),
    .s_wb(s_wb),
    .frame_start(frame_start),
    .pending(update_pending),
    .frame_cnt(frame_cnt),
    .act_mode(param_mode),
    .act_th(param_th),
    .shadow_mode(shadow_mode),
    .shadow_th(shadow_th),
    .always_en(always_en),
    .req(req),
    .shadow_chg(shadow_chg)
  );
  assign frame_start = mon_tvalid & mon_tready & mon_tuser;
  assign timeout = timer == TW'(TIMEOUT_CYCLES - 1);
  assign commit = state == WAIT_FRAME && (frame_start || timeout);
  assign update_pending = state == WAIT_FRAME;
  // a shadow change landing on the commit edge misses this commit, so stay armed for the next frame
  always_comb begin
    state_nx = state;
    if (state == IDLE)
      state_nx = (req | always_en) ? WAIT_FRAME : IDLE;
    else if (commit)
      state_nx = (always_en | shadow_chg) ? WAIT_FRAME : IDLE;
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state <= IDLE;
      timer <= '0;
      frame_cnt <= '0;
      param_mode <= INIT_PARAM_MODE;
      param_th <= TCOUNT_WIDTH'(INIT_PARAM_TH);
    end else begin
      state <= state_nx;
      timer <= (state != WAIT_FRAME || commit) ? '0 : timeout ? timer : timer + TW'(1);
      frame_cnt <= frame_cnt + 32'(frame_start);
      param_mode <= commit ? shadow_mode : param_mode;
      param_th <= commit ? shadow_th : param_th;
    end
endmodule

// File: tb/tb_video_mnist_seg_param_sched.sv
// tb_video_mnist_seg_param_sched: directed checks of frame-synchronous commit, timeout, ALWAYS and reset
module tb_video_mnist_seg_param_sched;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic mon_tuser = 1'b0, mon_tvalid = 1'b0, mon_tready = 1'b0;
  logic [2:0] param_mode;
  logic [3:0] param_th;
  logic update_pending;
  int n_chk = 0, n_pass = 0;
  logic [31:0] rd;
  video_mnist_seg_param_sched_if wb ();
  video_mnist_seg_param_sched #(.TIMEOUT_CYCLES(64)) dut (
    .aresetn(aresetn),
    .aclk(aclk),
    .s_wb(wb.slave),
    .mon_tuser(mon_tuser),
    .mon_tvalid(mon_tvalid),
    .mon_tready(mon_tready),
    .param_mode(param_mode),
    .param_th(param_th),
    .update_pending(update_pending)
  );
  always #5 aclk = ~aclk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic wb_wr(input logic [7:0] adr, input logic [31:0] dat);
    @(negedge aclk);
    wb.s_wb_adr_i = adr; wb.s_wb_dat_i = dat; wb.s_wb_we_i = 1'b1; wb.s_wb_stb_i = 1'b1;
    @(negedge aclk);
    wb.s_wb_we_i = 1'b0; wb.s_wb_stb_i = 1'b0;
  endtask
  task automatic rd_chk(input string tag, input logic [7:0] adr, input logic [31:0] exp);
    wb.s_wb_adr_i = adr; wb.s_wb_we_i = 1'b0; wb.s_wb_stb_i = 1'b1;
    #1;
    chk({tag, "_ack"}, 32'(wb.s_wb_ack_o), 32'd1);
    rd = wb.s_wb_dat_o;
    wb.s_wb_stb_i = 1'b0;
    chk(tag, rd, exp);
  endtask
  task automatic frame();
    @(negedge aclk);
    mon_tuser = 1'b1; mon_tvalid = 1'b1; mon_tready = 1'b1;
    @(negedge aclk);
    mon_tuser = 1'b0; mon_tvalid = 1'b0; mon_tready = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge aclk);
  endtask
  initial begin
    wb.s_wb_adr_i = '0; wb.s_wb_dat_i = '0; wb.s_wb_we_i = 1'b0;
    wb.s_wb_sel_i = '1; wb.s_wb_stb_i = 1'b0;
    idle(3);
    aresetn = 1'b1;
    idle(1);
    // reset state
    chk("rst_mode", 32'(param_mode), 32'd2);
    chk("rst_th", 32'(param_th), 32'd5);
    chk("rst_pending", 32'(update_pending), 32'd0);
    rd_chk("id", 8'd0, 32'h5345_4743);
    rd_chk("unmapped", 8'd9, 32'd0);
    // commit on first frame start after a request
    wb_wr(8'd4, 32'd3);
    wb_wr(8'd5, 32'hFFFF_FFF9);
    rd_chk("shadow_th_trunc", 8'd5, 32'd9);
    wb_wr(8'd1, 32'd1);
    chk("req_pending", 32'(update_pending), 32'd1);
    idle(40);
    chk("wait_pending", 32'(update_pending), 32'd1);
    chk("wait_mode_old", 32'(param_mode), 32'd2);
    rd_chk("status_pending", 8'd2, 32'd1);
    frame();
    chk("commit_mode", 32'(param_mode), 32'd3);
    chk("commit_th", 32'(param_th), 32'd9);
    chk("commit_pending", 32'(update_pending), 32'd0);
    rd_chk("frame_cnt1", 8'd3, 32'd1);
    rd_chk("act_mode_rd", 8'd6, 32'd3);
    // request coinciding with a frame start waits for the next one
    wb_wr(8'd4, 32'd1);
    @(negedge aclk);
    wb.s_wb_adr_i = 8'd1; wb.s_wb_dat_i = 32'd1; wb.s_wb_we_i = 1'b1; wb.s_wb_stb_i = 1'b1;
    mon_tuser = 1'b1; mon_tvalid = 1'b1; mon_tready = 1'b1;
    @(negedge aclk);
    wb.s_wb_we_i = 1'b0; wb.s_wb_stb_i = 1'b0;
    mon_tuser = 1'b0; mon_tvalid = 1'b0; mon_tready = 1'b0;
    chk("same_cycle_mode", 32'(param_mode), 32'd3);
    chk("same_cycle_pending", 32'(update_pending), 32'd1);
    frame();
    chk("next_frame_mode", 32'(param_mode), 32'd1);
    rd_chk("frame_cnt3", 8'd3, 32'd3);
    // forced commit after 64 cycles without a frame start
    wb_wr(8'd5, 32'd7);
    wb_wr(8'd1, 32'd1);
    idle(63);
    chk("to_pending_63", 32'(update_pending), 32'd1);
    chk("to_th_63", 32'(param_th), 32'd9);
    idle(1);
    chk("to_pending_64", 32'(update_pending), 32'd0);
    chk("to_th_64", 32'(param_th), 32'd7);
    // ALWAYS commits every frame; TH written between frames 2 and 3 lands at frame 3
    wb_wr(8'd1, 32'd2);
    rd_chk("ctl_always", 8'd1, 32'd2);
    idle(2);
    chk("always_pending", 32'(update_pending), 32'd1);
    frame();
    idle(3);
    chk("always_rearm", 32'(update_pending), 32'd1);
    frame();
    wb_wr(8'd5, 32'd12);
    idle(5);
    chk("always_th_f2", 32'(param_th), 32'd7);
    frame();
    chk("always_th_f3", 32'(param_th), 32'd12);
    chk("always_pending_f3", 32'(update_pending), 32'd1);
    // asynchronous reset in the middle of WAIT_FRAME
    @(negedge aclk);
    #2 aresetn = 1'b0;
    #1;
    chk("arst_mode", 32'(param_mode), 32'd2);
    chk("arst_th", 32'(param_th), 32'd5);
    chk("arst_pending", 32'(update_pending), 32'd0);
    idle(2);
    aresetn = 1'b1;
    idle(3);
    chk("arst_idle", 32'(update_pending), 32'd0);
    rd_chk("arst_ctl", 8'd1, 32'd0);
    rd_chk("arst_frame_cnt", 8'd3, 32'd0);
`ifdef VIDEO_MNIST_SEG_PARAM_SCHED_AUTO_CYCLE_EN
    // auto cycling every 2 frames: active 3, 4, 0
    wb_wr(8'd8, 32'd2);
    rd_chk("cycle_frames", 8'd8, 32'd2);
    wb_wr(8'd4, 32'd3);
    wb_wr(8'd1, 32'd1);
    frame();
    chk("auto_mode_a", 32'(param_mode), 32'd3);
    frame();
    chk("auto_mode_b", 32'(param_mode), 32'd3);
    rd_chk("auto_shadow_b", 8'd4, 32'd4);
    chk("auto_pending_b", 32'(update_pending), 32'd1);
    frame();
    chk("auto_mode_c", 32'(param_mode), 32'd4);
    frame();
    frame();
    chk("auto_mode_e", 32'(param_mode), 32'd0);
`else
    wb_wr(8'd8, 32'd2);
    rd_chk("cycle_frames_off", 8'd8, 32'd0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
